// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity link receive path.
// exp_parity is also the bench's reference for the parity rule.
package parity_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  localparam int unsigned MaxDataW     = 64;
  localparam int unsigned DefaultDataW = 8;
  // start + data + parity + stop
  localparam int unsigned FrameLen     = DefaultDataW + 3;

  // Zero-extension of narrower data does not change the reduction XOR.
  function automatic logic exp_parity(input logic [MaxDataW-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_rx_checker.sv
// Serial receiver for parity-protected frames: deserialises on bit_en strobes,
// rechecks parity and stop bit, and keeps a saturating error count.
module parity_rx_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

  state_e              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic                par_q;

  logic stop_perr;
  logic stop_err;

  assign stop_perr = par_q != exp_parity(MaxDataW'(shreg_q), ODD);
  assign stop_err  = stop_perr | ~rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      valid <= 1'b0;
      if (bit_en) begin
        unique case (state_q)
          StIdle: begin
            if (!rx) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
              busy      <= 1'b1;
            end
          end
          StData: begin
            shreg_q   <= {rx, shreg_q[DATA_W-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) state_q <= StParity;
          end
          StParity: begin
            par_q   <= rx;
            state_q <= StStop;
          end
          StStop: begin
            data_out   <= shreg_q;
            valid      <= 1'b1;
            parity_err <= stop_perr;
            // A bad stop bit still delivers the byte and its parity verdict.
            frame_err  <= ~rx;
            if (stop_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            state_q    <= StIdle;
            busy       <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_rx_checker.sv
// Bench for parity_rx_checker: even and odd instances share one serial line and
// are compared every cycle against a frame-level model, plus literal spot checks.
module tb_parity_rx_checker;
  import parity_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_en = 1'b0;
  logic rx = 1'b1;

  logic [7:0] data_o[2];
  logic       valid_o[2];
  logic       perr_o[2];
  logic       ferr_o[2];
  logic       busy_o[2];
  logic [7:0] cnt_o[2];

  parity_rx_checker #(.DATA_W(8), .ODD(1'b0), .CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
    .data_out(data_o[0]), .valid(valid_o[0]), .parity_err(perr_o[0]),
    .frame_err(ferr_o[0]), .busy(busy_o[0]), .err_cnt(cnt_o[0])
  );

  parity_rx_checker #(.DATA_W(8), .ODD(1'b1), .CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
    .data_out(data_o[1]), .valid(valid_o[1]), .parity_err(perr_o[1]),
    .frame_err(ferr_o[1]), .busy(busy_o[1]), .err_cnt(cnt_o[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  // Frame-level model state.
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_perr[2];
  logic       exp_ferr;
  logic       exp_busy;
  int         exp_cnt[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    exp_busy  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_perr[k] = 1'b0;
      exp_cnt[k]  = 0;
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_data%0d", k), 32'(data_o[k]), 32'(exp_data));
        chk($sformatf("cyc_valid%0d", k), 32'(valid_o[k]), 32'(exp_valid));
        chk($sformatf("cyc_perr%0d", k), 32'(perr_o[k]), 32'(exp_perr[k]));
        chk($sformatf("cyc_ferr%0d", k), 32'(ferr_o[k]), 32'(exp_ferr));
        chk($sformatf("cyc_busy%0d", k), 32'(busy_o[k]), 32'(exp_busy));
        chk($sformatf("cyc_cnt%0d", k), 32'(cnt_o[k]), 32'(exp_cnt[k]));
      end
      exp_valid = 1'b0;
    end
  end

  // gap < 0 picks a random 1..5 idle cycles before each strobe.
  task automatic strobe(input logic b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(1, 5)) : gap;
    bit_en = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    rx = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
    logic [FrameLen-1:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < int'(FrameLen); i++) begin
      strobe(bits[i], gap);
      if (i == 0) exp_busy = 1'b1;
    end
    exp_busy  = 1'b0;
    exp_valid = 1'b1;
    exp_data  = d;
    exp_ferr  = ~s;
    for (int k = 0; k < 2; k++) begin
      exp_perr[k] = (p != exp_parity(64'(d), 1'(k)));
      if ((exp_perr[k] || !s) && exp_cnt[k] < 255) exp_cnt[k]++;
    end
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_data", 32'(data_o[0]), 32'h0);
    chk("rst_valid", 32'(valid_o[0]), 32'h0);
    chk("rst_busy", 32'(busy_o[0]), 32'h0);
    chk("rst_cnt", 32'(cnt_o[0]), 32'h0);
    chk("rst_perr", 32'(perr_o[0]), 32'h0);
    chk("rst_ferr", 32'(ferr_o[0]), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b1;

    // Idle strobes with the line high must not start a frame.
    repeat (3) strobe(1'b1, 0);

    send_frame(8'h48, 1'b0, 1'b1, 0);
    chk("f48_valid", 32'(valid_o[0]), 32'h1);
    chk("f48_data", 32'(data_o[0]), 32'h48);
    chk("f48_perr", 32'(perr_o[0]), 32'h0);
    chk("f48_ferr", 32'(ferr_o[0]), 32'h0);
    chk("f48_cnt", 32'(cnt_o[0]), 32'h0);

    send_frame(8'h69, 1'b1, 1'b1, 0);
    chk("f69_data", 32'(data_o[0]), 32'h69);
    chk("f69_perr", 32'(perr_o[0]), 32'h1);
    chk("f69_cnt", 32'(cnt_o[0]), 32'h1);

    send_frame(8'h31, 1'b1, 1'b1, 0);
    chk("f31_perr", 32'(perr_o[0]), 32'h0);
    chk("f31_cnt", 32'(cnt_o[0]), 32'h1);

    send_frame(8'h31, 1'b0, 1'b1, 0);
    chk("odd31p0_perr", 32'(perr_o[1]), 32'h0);
    send_frame(8'h31, 1'b1, 1'b1, 0);
    chk("odd31p1_perr", 32'(perr_o[1]), 32'h1);

    send_frame(8'hA5, 1'b0, 1'b0, 0);
    chk("fA5_valid", 32'(valid_o[0]), 32'h1);
    chk("fA5_data", 32'(data_o[0]), 32'hA5);
    chk("fA5_ferr", 32'(ferr_o[0]), 32'h1);
    chk("fA5_perr", 32'(perr_o[0]), 32'h0);
    chk("fA5_cnt_even", 32'(cnt_o[0]), 32'h3);
    chk("fA5_cnt_odd", 32'(cnt_o[1]), 32'h4);

    // Start bit right after a low stop bit, then gapped strobes.
    send_frame(8'h5C, 1'b0, 1'b1, 0);
    send_frame(8'h48, 1'b0, 1'b1, 3);
    chk("gap_data", 32'(data_o[0]), 32'h48);
    send_frame(8'h69, 1'b1, 1'b1, -1);
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    send_frame(8'h7E, 1'b0, 1'b1, 3);

    // Abort mid-frame: start + 4 data bits, then asynchronous reset.
    strobe(1'b0, 0);
    exp_busy = 1'b1;
    for (int i = 0; i < 4; i++) strobe(1'b1, 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_data", 32'(data_o[0]), 32'h0);
    chk("abort_busy", 32'(busy_o[0]), 32'h0);
    chk("abort_cnt", 32'(cnt_o[0]), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(8'h0F, 1'b0, 1'b1, 0);
    chk("f0F_valid", 32'(valid_o[0]), 32'h1);
    chk("f0F_data", 32'(data_o[0]), 32'h0F);
    chk("f0F_perr", 32'(perr_o[0]), 32'h0);
    chk("f0F_cnt", 32'(cnt_o[0]), 32'h0);

    // 0x01 with parity 0 is bad for even, good for odd.
    for (int n = 0; n < 256; n++) send_frame(8'h01, 1'b0, 1'b1, 0);
    chk("sat_cnt_even", 32'(cnt_o[0]), 32'hFF);
    chk("sat_cnt_odd", 32'(cnt_o[1]), 32'h1);

    repeat (3) @(posedge clk);
    #1;
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_rx_checker.md
Name: parity_rx_checker

Overview:
- Serial receiver and checker for the 8-bit parity-protected frames our reduction-XOR parity generator protects.
- Deserialises start/data/parity/stop bits on a bit-rate strobe and recomputes parity over the received byte.
- Presents the byte with parity/framing status and a saturating error count.
- Sits at the receive end of the parity link, feeding downstream data consumers.

Parameters:
- DATA_W, 8, data bits per frame (LSB first).
- ODD, 0, parity sense: 0 = even (expected parity bit = XOR-reduce of data), 1 = odd (expected = XNOR-reduce of data).
- CNT_W, 8, width of error counter.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, reset: asynchronous, active-low.
- bit_en, input, 1, one-cycle strobe marking the sample point of each serial bit.
- rx, input, 1, serial line, idles high.
- data_out, output, DATA_W, last received byte.
- valid, output, 1, one-cycle pulse when a frame completes.
- parity_err, output, 1, parity mismatch status of the last frame.
- frame_err, output, 1, stop bit of the last frame sampled low.
- busy, output, 1, high while not in IDLE.
- err_cnt, output, CNT_W, count of frames with parity_err or frame_err; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, shift register=0, bit counter=0.
  - data_out=0, valid=0, parity_err=0, frame_err=0, busy=0, err_cnt=0.
  - Reset asserted mid-frame aborts the frame: no valid pulse, no count change.
- All state advances occur only on cycles with bit_en=1. With bit_en=0, every register holds, except valid, which is forced to 0.
- IDLE:
  - bit_en & rx=0 -> DATA, bit counter=0.
  - bit_en & rx=1 -> stay in IDLE.
- DATA:
  - On each bit_en, shift rx in LSB-first: shreg <= {rx, shreg[DATA_W-1:1]}, counter++.
  - On the bit_en that samples bit DATA_W-1 -> PARITY.
- PARITY: on bit_en, latch rx as p -> STOP.
- STOP: on bit_en, the following happen in the same registered update (visible the next cycle):
  - data_out <= shreg.
  - valid <= 1 for exactly one cycle.
  - parity_err <= (p != (^shreg ^ ODD)).
  - frame_err <= ~rx.
  - err_cnt increments if either error flag is set, unless err_cnt is already all-ones (then it holds).
  - state <= IDLE.
- Status flags:
  - data_out, parity_err and frame_err hold until the next completed frame.
  - A frame error does not suppress valid or the parity check.
- Latency: valid is asserted the cycle after the stop-bit bit_en.
- Frame length: 1 start + DATA_W data + 1 parity + 1 stop = DATA_W+3 strobes.
- Back-to-back frames:
  - A start bit can be accepted on the strobe right after the stop strobe; IDLE needs only one strobe with rx=0.
  - After a frame_err (stop sampled low), the FSM returns to IDLE. A low rx on the next strobe is treated as a new start bit.
- busy = (state != IDLE), registered with the state.
- Counter: width derived as clog2(DATA_W); no wrap inside a frame.

Decomposition:
- Package parity_pkg holds:
  - state enum {IDLE, DATA, PARITY, STOP}.
  - Frame-length constant.
  - Function exp_parity(data, odd) returning ^data ^ odd.
- The bench reuses exp_parity as its reference model.
- No sub-module: FSM, shift register and counter live in one module.

Test Plan:
- Even parity (ODD=0), frame data=0x48, parity bit 0, stop 1 -> valid pulse, data_out=0x48, parity_err=0, frame_err=0, err_cnt=0.
- ODD=0, data=0x69, parity bit 1 (wrong, 0x69 has four ones) -> data_out=0x69, parity_err=1, err_cnt=1. Next frame data=0x31, parity bit 1 -> parity_err=0, err_cnt stays 1.
- ODD=1, data=0x31, parity bit 0 -> parity_err=0. Same frame with parity bit 1 -> parity_err=1.
- Stop bit sampled 0 on data=0xA5 with correct parity -> valid pulse, data_out=0xA5, frame_err=1, parity_err=0, err_cnt+1.
- bit_en asserted every 4th cycle with a random gap pattern -> results identical to the contiguous-strobe case. valid is exactly one clk wide. Two back-to-back frames each produce one valid.
- rst_n pulsed low after 4 data bits -> outputs return to 0 asynchronously, no valid. A following clean frame of 0x0F with parity 0 -> valid, no errors.
- Additional check, 256 consecutive bad-parity frames -> err_cnt saturates at 0xFF.
